// File: rtl/nn_arch_pkg.sv
// Shared neural-net architecture constants and types.
// Used by the hidden and output layer cores.
package nn_arch_pkg;

    localparam int INPUT_SIZE  = 784;
    localparam int HIDDEN_SIZE = 32;
    localparam int OUTPUT_SIZE = 10;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    function automatic acc_t relu(acc_t v);
        return (v < 0) ? '0 : v;
    endfunction

endpackage

// File: rtl/hidden_mac_lane.sv
// One hidden-neuron accumulator lane.
// Loads a bias, then accumulates sign-extended products.
module hidden_mac_lane
    import nn_arch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_bias,
    input  logic  mac_en,
    input  data_t x,
    input  data_t w,
    input  acc_t  bias,
    output acc_t  acc
);

    // bias load wins over accumulate; sums wrap modulo 2^ACC_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= bias;
        end else if (mac_en) begin
            acc <= acc + acc_t'(x) * acc_t'(w);
        end
    end

endmodule

// File: rtl/hidden_core.sv
// Hidden layer: h[j] = ReLU(bias[j] + sum_i x[i]*w[i][j]).
// LANES neurons per group, one input feature per cycle.
module hidden_core
    import nn_arch_pkg::*;
#(
    parameter int INPUT_SIZE  = nn_arch_pkg::INPUT_SIZE,
    parameter int HIDDEN_SIZE = nn_arch_pkg::HIDDEN_SIZE,
    parameter int LANES       = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  data_t x      [INPUT_SIZE],
    input  data_t weight [INPUT_SIZE][HIDDEN_SIZE],
    input  acc_t  bias   [HIDDEN_SIZE],
    output acc_t  h_out  [HIDDEN_SIZE],
    output logic  busy,
    output logic  finished
);

    localparam int G  = HIDDEN_SIZE / LANES;
    localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int HW = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WRITE,
        DONE
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  in_idx;
    logic [GW-1:0]  group;
    logic           load_bias;
    logic           mac_en;
    logic           wr_en;
    logic           last_in;
    logic           last_grp;
    data_t          cur_x;
    acc_t           acc    [LANES];
    logic [HW-1:0]  wr_idx [LANES];
    logic [HW-1:0]  b_idx  [LANES];

    assign last_in  = (in_idx == IW'(INPUT_SIZE - 1));
    assign last_grp = (group == GW'(G - 1));
    assign busy     = (state != IDLE);
    assign cur_x    = x[in_idx];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // IDLE loads group 0 biases; WRITE preloads the next group
        assign wr_idx[l] = HW'(int'(group) * LANES + l);
        assign b_idx[l]  = HW'(((state == IDLE) ? 0 : int'(group) + 1)
                               * LANES + l);

        hidden_mac_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_bias (load_bias),
            .mac_en    (mac_en),
            .x         (cur_x),
            .w         (weight[in_idx][wr_idx[l]]),
            .bias      (bias[b_idx[l]]),
            .acc       (acc[l])
        );
    end

    // state, feature index, group counter and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_idx   <= '0;
            group    <= '0;
            finished <= 1'b0;
        end else begin
            state    <= state_n;
            finished <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        in_idx <= '0;
                        group  <= '0;
                    end
                end
                ACCUM: begin
                    if (!last_in) in_idx <= in_idx + 1'b1;
                end
                WRITE: begin
                    if (!last_grp) begin
                        group  <= group + 1'b1;
                        in_idx <= '0;
                    end
                end
                DONE: ;
            endcase
        end
    end

    // next-state and lane control decode
    always_comb begin
        state_n   = state;
        load_bias = 1'b0;
        mac_en    = 1'b0;
        wr_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load_bias = 1'b1;
                    state_n   = ACCUM;
                end
            end
            ACCUM: begin
                mac_en = 1'b1;
                if (last_in) state_n = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                if (last_grp) begin
                    state_n = DONE;
                end else begin
                    load_bias = 1'b1;
                    state_n   = ACCUM;
                end
            end
            DONE: state_n = IDLE;
        endcase
    end

    // activations are kept between runs; each group overwrites its slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < HIDDEN_SIZE; j++) h_out[j] <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                h_out[wr_idx[l]] <= relu(acc[l]);
            end
        end
    end

endmodule
